selectable_input4: RTL and testbench

- 1:4 routing demux: one signed 16-bit source goes to one of four registered output channels.
- The channel is chosen by a 6-bit select register.
- Switchover is break-before-make with a programmable dead time, so no two channels are ever driven from the source in the same window.
- Unselected outputs hold their last value, so a servo or DAC channel that is released keeps its final setpoint.
- Sits between a single loop filter or waveform source and up to four DAC/actuator paths.

---
 rtl/selectable_input4_pkg.sv | 10 +
 rtl/selectable_input4_if.sv | 17 +
 rtl/selectable_input4_dead_time_counter.sv | 17 +
 rtl/selectable_input4.sv | 74 +++++++
 tb/tb_selectable_input4.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/selectable_input4_pkg.sv
// selectable_input4_pkg: shared types, constants and select decoding for the 1:4 routing demux
package selectable_input4_pkg;
  typedef enum logic [1:0] {PARKED, DEAD, ROUTE} state_t;
  localparam int NCH = 4;
  localparam int SEL_W = 6;
  localparam logic [SEL_W-1:0] SEL_PARK = 6'd63;
  function automatic logic [NCH-1:0] onehot(input logic [SEL_W-1:0] s);
    return (s < SEL_W'(NCH)) ? ({{(NCH-1){1'b0}}, 1'b1} << s[1:0]) : '0;
  endfunction
endpackage

// File: rtl/selectable_input4_if.sv
// selectable_input4_if: source/select bus and the four channel outputs of the demux
//   master: drives sel, dead, in; observes out0..out3, active, busy
//   slave:  the demux itself
interface selectable_input4_if #(parameter int W = 16, parameter int DEAD_W = 8);
  import selectable_input4_pkg::*;
  logic [SEL_W-1:0] sel;
  logic [DEAD_W-1:0] dead;
  logic signed [W-1:0] in;
  logic signed [W-1:0] out0;
  logic signed [W-1:0] out1;
  logic signed [W-1:0] out2;
  logic signed [W-1:0] out3;
  logic [NCH-1:0] active;
  logic busy;
  modport master (output sel, dead, in, input out0, out1, out2, out3, active, busy);
  modport slave (input sel, dead, in, output out0, out1, out2, out3, active, busy);
endinterface

// File: rtl/selectable_input4_dead_time_counter.sv
// dead_time_counter: loadable down-counter that stops at zero
//   load/val: reload the count; dec: step down (ignored at zero); zero: count is 0
module dead_time_counter #(parameter int DEAD_W = 8) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  input  logic [DEAD_W-1:0] val,
  output logic zero
);
  logic [DEAD_W-1:0] cnt;
  assign zero = cnt == '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= val;
    else if (dec && !zero) cnt <= cnt - 1'b1;
endmodule

// File: rtl/selectable_input4.sv
// selectable_input4: break-before-make 1:4 demux of a signed source onto registered hold-last-value channels
//   clk/rst: clock, async active-high reset
//   bus: sel/dead/in from the source side, out0..out3/active/busy towards the channels
module selectable_input4
  import selectable_input4_pkg::*;
#(parameter int W = 16, parameter int DEAD_W = 8) (
  input logic clk,
  input logic rst,
  selectable_input4_if.slave bus
);
  state_t state, nxt;
  logic [SEL_W-1:0] sel_q, cur, cur_nxt;
  logic signed [W-1:0] outs [NCH];
  logic [NCH-1:0] active_q;
  logic busy_q, sel_ok, same, load, dec, zero, wr;
  dead_time_counter #(.DEAD_W(DEAD_W)) u_cnt (
    .clk(clk), .rst(rst), .load(load), .dec(dec), .val(bus.dead), .zero(zero)
  );
  assign sel_ok = sel_q < SEL_W'(NCH);
  assign same = sel_q == cur;
  assign wr = state == ROUTE && sel_ok && same;
  always_comb begin
    nxt = state;
    cur_nxt = cur;
    load = 1'b0;
    dec = 1'b0;
    unique case (state)
      PARKED:
        if (sel_ok) begin
          nxt = DEAD;
          cur_nxt = sel_q;
          load = 1'b1;
        end
      DEAD:
        if (!sel_ok) nxt = PARKED;
        else if (!same) begin
          cur_nxt = sel_q;
          load = 1'b1;
        end
        else if (zero) nxt = ROUTE;
        else dec = 1'b1;
      ROUTE:
        if (!sel_ok) nxt = PARKED;
        else if (!same) begin
          nxt = DEAD;
          cur_nxt = sel_q;
          load = 1'b1;
        end
      default: nxt = PARKED;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= PARKED;
      sel_q <= SEL_PARK;
      cur <= SEL_PARK;
      active_q <= '0;
      busy_q <= 1'b0;
      for (int i = 0; i < NCH; i++) outs[i] <= '0;
    end else begin
      state <= nxt;
      sel_q <= bus.sel;
      cur <= cur_nxt;
      busy_q <= nxt == DEAD;
      active_q <= nxt == ROUTE ? onehot(cur_nxt) : '0;
      if (wr) outs[cur[1:0]] <= bus.in;
    end
  assign bus.out0 = outs[0];
  assign bus.out1 = outs[1];
  assign bus.out2 = outs[2];
  assign bus.out3 = outs[3];
  assign bus.active = active_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_selectable_input4.sv
// tb_selectable_input4: directed scenarios for the break-before-make demux
module tb_selectable_input4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  selectable_input4_if #(.W(16), .DEAD_W(8)) bus();
  selectable_input4 #(.W(16), .DEAD_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.sel = 6'd63;
    bus.dead = 8'd0;
    bus.in = 16'sd0;
    tick();
    tick();
    total++;
    if ({bus.out0, bus.out1, bus.out2, bus.out3} !== 64'd0) begin
      bad++;
      $display("FAIL reset_outs got=%h exp=0", {bus.out0, bus.out1, bus.out2, bus.out3});
    end
    total++;
    if (bus.active !== 4'b0000 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags active=%b busy=%b exp 0000/0", bus.active, bus.busy);
    end
    rst = 1'b0;
  endtask

  task automatic test_route;
    logic signed [15:0] e_out;
    logic e_busy;
    logic [3:0] e_act;
    bus.sel = 6'd0;
    bus.dead = 8'd3;
    bus.in = 16'sd100;
    for (int i = 1; i <= 10; i++) begin
      tick();
      bus.in = 16'(100 + i);
      e_out = (i >= 7) ? 16'(100 + i - 1) : 16'sd0;
      e_busy = (i >= 2 && i <= 5);
      e_act = (i >= 6) ? 4'b0001 : 4'b0000;
      total++;
      if (bus.out0 !== e_out) begin
        bad++;
        $display("FAIL route_out0 i=%0d got=%0d exp=%0d", i, bus.out0, e_out);
      end
      total++;
      if (bus.busy !== e_busy || bus.active !== e_act) begin
        bad++;
        $display("FAIL route_flags i=%0d busy=%b active=%b exp %b/%b", i, bus.busy, bus.active, e_busy, e_act);
      end
      total++;
      if ({bus.out1, bus.out2, bus.out3} !== 48'd0) begin
        bad++;
        $display("FAIL route_others i=%0d got=%h exp=0", i, {bus.out1, bus.out2, bus.out3});
      end
    end
  endtask

  task automatic test_switch;
    logic signed [15:0] e_out2;
    logic [3:0] e_act;
    bus.in = 16'sd500;
    tick();
    total++;
    if (bus.out0 !== 16'sd500) begin
      bad++;
      $display("FAIL switch_pre out0 got=%0d exp=500", bus.out0);
    end
    bus.sel = 6'd2;
    bus.dead = 8'd0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) bus.in = -16'sd7;
      e_out2 = (i >= 4) ? -16'sd7 : 16'sd0;
      e_act = (i == 1) ? 4'b0001 : (i >= 3) ? 4'b0100 : 4'b0000;
      total++;
      if (bus.out0 !== 16'sd500) begin
        bad++;
        $display("FAIL switch_out0 i=%0d got=%0d exp=500", i, bus.out0);
      end
      total++;
      if (bus.out2 !== e_out2) begin
        bad++;
        $display("FAIL switch_out2 i=%0d got=%0d exp=%0d", i, bus.out2, e_out2);
      end
      total++;
      if (bus.busy !== (i == 2) || bus.active !== e_act) begin
        bad++;
        $display("FAIL switch_flags i=%0d busy=%b active=%b exp %b/%b", i, bus.busy, bus.active, i == 2, e_act);
      end
    end
  endtask

  task automatic test_restart;
    logic signed [15:0] e_out3;
    logic [3:0] e_act;
    bus.sel = 6'd1;
    bus.dead = 8'd10;
    for (int i = 1; i <= 21; i++) begin
      tick();
      if (i == 1) bus.in = 16'sd333;
      if (i == 6) bus.sel = 6'd3;
      e_out3 = (i >= 20) ? 16'sd333 : 16'sd0;
      e_act = (i == 1) ? 4'b0100 : (i >= 19) ? 4'b1000 : 4'b0000;
      total++;
      if (bus.out1 !== 16'sd0 || bus.out2 !== -16'sd7) begin
        bad++;
        $display("FAIL restart_hold i=%0d out1=%0d out2=%0d exp 0/-7", i, bus.out1, bus.out2);
      end
      total++;
      if (bus.out3 !== e_out3) begin
        bad++;
        $display("FAIL restart_out3 i=%0d got=%0d exp=%0d", i, bus.out3, e_out3);
      end
      total++;
      if (bus.busy !== (i >= 2 && i <= 18) || bus.active !== e_act) begin
        bad++;
        $display("FAIL restart_flags i=%0d busy=%b active=%b exp %b/%b", i, bus.busy, bus.active, i >= 2 && i <= 18, e_act);
      end
    end
  endtask

  task automatic test_park;
    logic signed [15:0] e_out1;
    bus.sel = 6'd1;
    bus.dead = 8'd0;
    tick();
    bus.in = 16'sd1234;
    tick();
    tick();
    tick();
    total++;
    if (bus.out1 !== 16'sd1234 || bus.out3 !== 16'sd333) begin
      bad++;
      $display("FAIL park_setup out1=%0d out3=%0d exp 1234/333", bus.out1, bus.out3);
    end
    bus.sel = 6'h3F;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i == 1) bus.in = 16'sd999;
      total++;
      if (bus.out0 !== 16'sd500 || bus.out1 !== 16'sd1234 || bus.out2 !== -16'sd7 || bus.out3 !== 16'sd333) begin
        bad++;
        $display("FAIL park_hold i=%0d got=%0d,%0d,%0d,%0d exp 500,1234,-7,333", i, bus.out0, bus.out1, bus.out2, bus.out3);
      end
      total++;
      if (bus.busy !== 1'b0 || bus.active !== ((i == 1) ? 4'b0010 : 4'b0000)) begin
        bad++;
        $display("FAIL park_flags i=%0d busy=%b active=%b", i, bus.busy, bus.active);
      end
    end
    bus.sel = 6'd1;
    bus.dead = 8'd2;
    for (int i = 1; i <= 7; i++) begin
      tick();
      e_out1 = (i >= 6) ? 16'sd999 : 16'sd1234;
      total++;
      if (bus.out1 !== e_out1) begin
        bad++;
        $display("FAIL unpark_out1 i=%0d got=%0d exp=%0d", i, bus.out1, e_out1);
      end
      total++;
      if (bus.busy !== (i >= 2 && i <= 4) || bus.active !== ((i >= 5) ? 4'b0010 : 4'b0000)) begin
        bad++;
        $display("FAIL unpark_flags i=%0d busy=%b active=%b", i, bus.busy, bus.active);
      end
    end
  endtask

  task automatic test_async_reset;
    logic signed [15:0] e_out0;
    bus.sel = 6'd0;
    bus.dead = 8'd5;
    bus.in = 16'sd77;
    tick();
    tick();
    tick();
    total++;
    if (bus.busy !== 1'b1 || bus.active !== 4'b0000) begin
      bad++;
      $display("FAIL areset_pre busy=%b active=%b exp 1/0000", bus.busy, bus.active);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({bus.out0, bus.out1, bus.out2, bus.out3} !== 64'd0 || bus.active !== 4'b0000 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL areset_now outs=%h active=%b busy=%b exp all 0", {bus.out0, bus.out1, bus.out2, bus.out3}, bus.active, bus.busy);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int r = 1; r <= 10; r++) begin
      tick();
      e_out0 = (r >= 9) ? 16'sd77 : 16'sd0;
      total++;
      if (bus.out0 !== e_out0) begin
        bad++;
        $display("FAIL areset_out0 r=%0d got=%0d exp=%0d", r, bus.out0, e_out0);
      end
      total++;
      if (bus.busy !== (r >= 2 && r <= 7) || bus.active !== ((r >= 8) ? 4'b0001 : 4'b0000)) begin
        bad++;
        $display("FAIL areset_flags r=%0d busy=%b active=%b", r, bus.busy, bus.active);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic signed [15:0] v;
    bus.sel = 6'd3;
    bus.dead = 8'd0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 1) ? 16'sh7FFF : 16'sh8000;
      bus.sel = 6'd3;
      bus.in = v;
      tick();
      total++;
      if (bus.out3 !== v) begin
        bad++;
        $display("FAIL b2b_out3 i=%0d got=%0d exp=%0d", i, bus.out3, v);
      end
      total++;
      if (bus.busy !== 1'b0 || bus.active !== 4'b1000) begin
        bad++;
        $display("FAIL b2b_flags i=%0d busy=%b active=%b exp 0/1000", i, bus.busy, bus.active);
      end
    end
    total++;
    if (bus.out0 !== 16'sd77) begin
      bad++;
      $display("FAIL b2b_out0 got=%0d exp=77", bus.out0);
    end
  endtask

  initial begin
    test_reset();
    test_route();
    test_switch();
    test_restart();
    test_park();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
